sram_dp_ctrl: RTL and testbench

Parametrised true dual-port SRAM for FrodoKEM matrix and vector storage. It extends the basic dual-port SRAM with per-port byte-lane write enables, a selectable 1- or 2-cycle read pipeline with valid strobes, and a defined read-during-write policy. It also adds same-address write arbitration and a hardware clear engine that zeroes the array after reset or on request. It sits between the arithmetic/sampling datapaths and the storage array and replaces direct instantiation of the bare SRAM.

---
 rtl/sram_dp_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_sram_dp_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_ctrl.sv
// sram_dp_ctrl: true dual-port word SRAM with per-lane write enables,
// 1- or 2-cycle registered read pipeline with valid strobes, same-address
// write arbitration (port 0 lanes win), selectable cross-port
// read-during-write result and a clear engine that zeroes the array.
//
// Parameter constraints (not checked in hardware):
//   WIDTH % LANE_WIDTH == 0, DEPTH <= 1<<ADDR_WIDTH, READ_LAT in {1,2}.
// Addresses at or above DEPTH are dropped on write and read back as zero.
module sram_dp_ctrl #(
  parameter int WIDTH          = 16,
  parameter int LANE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int DEPTH          = 1 << ADDR_WIDTH,
  parameter int READ_LAT       = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NUM_LANES     = WIDTH / LANE_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_ce_n_0,
  input  logic                  i_rdwr_n_0,
  input  logic [ADDR_WIDTH-1:0] i_addr_0,
  input  logic [NUM_LANES-1:0]  i_be_0,
  input  logic [WIDTH-1:0]      i_data_0,
  input  logic                  i_ce_n_1,
  input  logic                  i_rdwr_n_1,
  input  logic [ADDR_WIDTH-1:0] i_addr_1,
  input  logic [NUM_LANES-1:0]  i_be_1,
  input  logic [WIDTH-1:0]      i_data_1,
  output logic [WIDTH-1:0]      o_data_0,
  output logic [WIDTH-1:0]      o_data_1,
  output logic                  o_valid_0,
  output logic                  o_valid_1,
  output logic                  o_busy,
  output logic                  o_collision
);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT   = (ADDR_WIDTH + 1)'(DEPTH);

  // ---------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------
  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_nxt;
  logic                  clr_we;

  // State and clear-address registers.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: sweep every address with zeros, or wait for a clear request.
  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        if (i_clear) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_READY;
    endcase
  end

  // Busy comes straight from the state flop, so it is a registered output.
  assign o_busy = (state == ST_CLEAR);

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic ready;
  logic accept_0, accept_1;
  logic wr_0, wr_1, rd_0, rd_1;
  logic same_addr;
  logic in_range_0, in_range_1;

  // A clear request in READY wins over port traffic in the same cycle.
  assign ready      = (state == ST_READY);
  assign accept_0   = ready & ~i_clear & ~i_ce_n_0;
  assign accept_1   = ready & ~i_clear & ~i_ce_n_1;
  assign wr_0       = accept_0 & ~i_rdwr_n_0;
  assign wr_1       = accept_1 & ~i_rdwr_n_1;
  assign rd_0       = accept_0 & i_rdwr_n_0;
  assign rd_1       = accept_1 & i_rdwr_n_1;
  assign same_addr  = (i_addr_0 == i_addr_1);
  assign in_range_0 = ({1'b0, i_addr_0} < DEPTH_EXT);
  assign in_range_1 = ({1'b0, i_addr_1} < DEPTH_EXT);

  // Per-lane write enables. On a same-address double write, port 1 is masked
  // off every lane port 0 writes, so port 0 wins lane by lane.
  logic [NUM_LANES-1:0] lane_we_0;
  logic [NUM_LANES-1:0] lane_we_1;
  logic [NUM_LANES-1:0] lane_block_1;

  assign lane_block_1 = (wr_0 && same_addr) ? i_be_0 : '0;
  assign lane_we_0    = (wr_0 && in_range_0) ? i_be_0 : '0;
  assign lane_we_1    = (wr_1 && in_range_1) ? (i_be_1 & ~lane_block_1) : '0;

  // ---------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];

  // Array write port: clear engine or lane-masked port writes. Writes are
  // suppressed while reset is held so stray requests cannot corrupt data.
  // NOTE: the array itself has no reset; zeroing is the clear engine's job,
  // which keeps this a plain SRAM macro rather than a bank of resettable flops.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (clr_we) begin
        mem[cnt] <= '0;
      end else begin
        for (int k = 0; k < NUM_LANES; k++) begin
          if (lane_we_0[k]) mem[i_addr_0][k*LANE_WIDTH +: LANE_WIDTH] <= i_data_0[k*LANE_WIDTH +: LANE_WIDTH];
          if (lane_we_1[k]) mem[i_addr_1][k*LANE_WIDTH +: LANE_WIDTH] <= i_data_1[k*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read data selection
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] old_0, old_1;
  logic [WIDTH-1:0] rd_word [2];
  logic [1:0]       rd_req;

  assign old_0  = in_range_0 ? mem[i_addr_0] : '0;
  assign old_1  = in_range_1 ? mem[i_addr_1] : '0;
  assign rd_req = {rd_1, rd_0};

  // Read word: pre-write contents, or with the other port's written lanes
  // merged in when new-data read-during-write behaviour is selected.
  always_comb begin
    rd_word[0] = old_0;
    rd_word[1] = old_1;
    if (RDW_MODE != 0) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (wr_1 && same_addr && lane_we_1[k]) rd_word[0][k*LANE_WIDTH +: LANE_WIDTH] = i_data_1[k*LANE_WIDTH +: LANE_WIDTH];
        if (wr_0 && same_addr && lane_we_0[k]) rd_word[1][k*LANE_WIDTH +: LANE_WIDTH] = i_data_0[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------
  logic [1:0]       valid_q;
  logic [WIDTH-1:0] data_q [2];

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [1:0]       s1_valid;
      logic [WIDTH-1:0] s1_data [2];

      // Two-stage read: capture, then present. Stage 1 keeps draining while
      // the clear engine runs so in-flight reads still complete.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          s1_valid <= '0;
          s1_data  <= '{default: '0};
          valid_q  <= '0;
          data_q   <= '{default: '0};
        end else begin
          s1_valid <= rd_req;
          valid_q  <= s1_valid;
          for (int p = 0; p < 2; p++) begin
            if (rd_req[p])   s1_data[p] <= rd_word[p];
            if (s1_valid[p]) data_q[p]  <= s1_data[p];
          end
        end
      end
    end else begin : g_lat1
      // Single-stage read: data register loads only on an accepted read.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          valid_q <= '0;
          data_q  <= '{default: '0};
        end else begin
          valid_q <= rd_req;
          for (int p = 0; p < 2; p++) begin
            if (rd_req[p]) data_q[p] <= rd_word[p];
          end
        end
      end
    end
  endgenerate

  assign o_data_0  = data_q[0];
  assign o_data_1  = data_q[1];
  assign o_valid_0 = valid_q[0];
  assign o_valid_1 = valid_q[1];

  // ---------------------------------------------------------------------
  // Collision flag
  // ---------------------------------------------------------------------

  // One-cycle pulse after both ports wrote the same address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_collision <= 1'b0;
    end else begin
      o_collision <= wr_0 & wr_1 & same_addr;
    end
  end

endmodule

// File: tb/tb_sram_dp_ctrl.sv
// Testbench for sram_dp_ctrl. Two instances share one stimulus stream:
// instance 0 uses READ_LAT=1/RDW_MODE=0, instance 1 uses READ_LAT=2/RDW_MODE=1.
// A word-level reference model predicts every output each cycle.
module tb_sram_dp_ctrl;

  localparam int W     = 16;
  localparam int LW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NL    = W / LW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clear;

  logic          ce_n   [2];
  logic          rdwr_n [2];
  logic [AW-1:0] addr   [2];
  logic [NL-1:0] be     [2];
  logic [W-1:0]  wdata  [2];

  logic [W-1:0] q_data  [2][2];
  logic         q_valid [2][2];
  logic         q_busy  [2];
  logic         q_col   [2];

  always #5 clk = ~clk;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    sram_dp_ctrl #(
      .WIDTH(W), .LANE_WIDTH(LW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
      .READ_LAT(d + 1), .RDW_MODE(d), .CLEAR_ON_RESET(1)
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
      .i_ce_n_0(ce_n[0]), .i_rdwr_n_0(rdwr_n[0]), .i_addr_0(addr[0]), .i_be_0(be[0]), .i_data_0(wdata[0]),
      .i_ce_n_1(ce_n[1]), .i_rdwr_n_1(rdwr_n[1]), .i_addr_1(addr[1]), .i_be_1(be[1]), .i_data_1(wdata[1]),
      .o_data_0(q_data[d][0]), .o_data_1(q_data[d][1]),
      .o_valid_0(q_valid[d][0]), .o_valid_1(q_valid[d][1]),
      .o_busy(q_busy[d]), .o_collision(q_col[d])
    );
  end

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  logic [W-1:0] mm [DEPTH];
  int           clear_left;
  logic         pend_v [2][2];
  logic [W-1:0] pend_d [2][2];
  logic         exp_v  [2][2];
  logic [W-1:0] exp_d  [2][2];
  logic         exp_col;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                         input logic [NL-1:0] lanes);
    logic [W-1:0] r;
    r = old_w;
    for (int k = 0; k < NL; k++) if (lanes[k]) r[k*LW +: LW] = new_w[k*LW +: LW];
    return r;
  endfunction

  task automatic model_reset();
    clear_left = DEPTH;
    exp_col    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        pend_v[d][p] = 1'b0;
        pend_d[d][p] = '0;
        exp_v[d][p]  = 1'b0;
        exp_d[d][p]  = '0;
      end
    end
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic         rv [2];
    logic [W-1:0] rd [2][2];
    logic         wr [2];
    logic [W-1:0] base;
    int           q;
    exp_col = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0; wr[p] = 1'b0; rd[0][p] = '0; rd[1][p] = '0;
    end
    if (clear_left > 0) begin
      mm[DEPTH - clear_left] = '0;
      clear_left--;
    end else if (clear) begin
      clear_left = DEPTH;
    end else begin
      for (int p = 0; p < 2; p++) wr[p] = !ce_n[p] && !rdwr_n[p];
      for (int p = 0; p < 2; p++) begin
        if (!ce_n[p] && rdwr_n[p]) begin
          q        = 1 - p;
          base     = mm[addr[p]];
          rv[p]    = 1'b1;
          rd[0][p] = base;
          rd[1][p] = (wr[q] && addr[q] == addr[p]) ? merge(base, wdata[q], be[q]) : base;
        end
      end
      exp_col = wr[0] && wr[1] && (addr[0] == addr[1]);
      // Port 1 first, then port 0 on top: port 0 lanes win.
      if (wr[1]) mm[addr[1]] = merge(mm[addr[1]], wdata[1], be[1]);
      if (wr[0]) mm[addr[0]] = merge(mm[addr[0]], wdata[0], be[0]);
    end
    for (int p = 0; p < 2; p++) begin
      // One-cycle latency instance.
      exp_v[0][p] = rv[p];
      if (rv[p]) exp_d[0][p] = rd[0][p];
      // Two-cycle latency instance: result appears one edge later.
      exp_v[1][p] = pend_v[1][p];
      if (pend_v[1][p]) exp_d[1][p] = pend_d[1][p];
      pend_v[1][p] = rv[p];
      pend_d[1][p] = rd[1][p];
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("d%0d_valid_%0d", d, p), 32'(q_valid[d][p]), 32'(exp_v[d][p]));
        check($sformatf("d%0d_data_%0d", d, p), 32'(q_data[d][p]), 32'(exp_d[d][p]));
      end
      check($sformatf("d%0d_busy", d), 32'(q_busy[d]), 32'(clear_left > 0));
      check($sformatf("d%0d_collision", d), 32'(q_col[d]), 32'(exp_col));
    end
  endtask

  // One clock cycle: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic idle();
    clear = 1'b0;
    for (int p = 0; p < 2; p++) begin
      ce_n[p] = 1'b1; rdwr_n[p] = 1'b1; addr[p] = '0; be[p] = '0; wdata[p] = '0;
    end
  endtask

  task automatic req(input int p, input bit rd, input int a, input logic [NL-1:0] b, input logic [W-1:0] dv);
    ce_n[p]   = 1'b0;
    rdwr_n[p] = rd;
    addr[p]   = AW'(a);
    be[p]     = b;
    wdata[p]  = dv;
  endtask

  task automatic random_req(input int p);
    int a;
    a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
    if ($urandom_range(0, 3) != 0)
      req(p, 1'($urandom_range(0, 1)), a, NL'($urandom_range(0, 3)), W'($urandom));
  endtask

  // Called at a falling edge; holds reset over one rising edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_d%0d_busy", d), 32'(q_busy[d]), 32'd1);
      check($sformatf("rst_d%0d_collision", d), 32'(q_col[d]), 32'd0);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rst_d%0d_valid_%0d", d, p), 32'(q_valid[d][p]), 32'd0);
        check($sformatf("rst_d%0d_data_%0d", d, p), 32'(q_data[d][p]), 32'd0);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_busy", 32'(q_busy[0]), 32'd1);
    rst_n = 1'b1;
  endtask

  // Count busy cycles, optionally with port traffic and clear pulses that must be ignored.
  task automatic count_busy(input string tag, input bit noisy);
    int n;
    n = 0;
    while (q_busy[0] && n < 40) begin
      idle();
      if (noisy) begin
        random_req(0);
        random_req(1);
        clear = ($urandom_range(0, 7) == 0);
      end
      step();
      n++;
    end
    idle();
    check(tag, 32'(n), 32'(DEPTH));
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      req(0, 1'b1, a, '0, '0);
      req(1, 1'b1, DEPTH - 1 - a, '0, '0);
      step();
    end
    idle();
    step();
    step();
  endtask

  // ------------------------------------------------------------------
  // Test sequence
  // ------------------------------------------------------------------
  initial begin
    int pulses;
    n_checks = 0;
    n_fail   = 0;
    for (int a = 0; a < DEPTH; a++) mm[a] = '0;
    model_reset();
    idle();

    // Power-on clear with ignored traffic while busy.
    @(negedge clk);
    apply_reset();
    count_busy("por_busy_len", 1'b1);

    // Preload 0xFFFF everywhere, then a requested clear.
    for (int a = 0; a < DEPTH; a++) begin
      idle(); req(0, 1'b0, a, 2'b11, 16'hFFFF); step();
    end
    idle(); clear = 1'b1; req(1, 1'b0, 2, 2'b11, 16'h5555); step();
    check("clr_busy_rise", 32'(q_busy[0]), 32'd1);
    count_busy("clr_busy_len", 1'b0);
    read_all();

    // Byte-lane writes.
    idle(); req(0, 1'b0, 3, 2'b11, 16'hABCD); step();
    idle(); req(0, 1'b0, 3, 2'b10, 16'h1200); step();
    idle(); req(0, 1'b1, 3, '0, '0); step();
    check("be_lat1_valid", 32'(q_valid[0][0]), 32'd1);
    check("be_lat1_data", 32'(q_data[0][0]), 32'h12CD);
    check("be_lat2_early", 32'(q_valid[1][0]), 32'd0);
    idle(); step();
    check("be_lat2_valid", 32'(q_valid[1][0]), 32'd1);
    check("be_lat2_data", 32'(q_data[1][0]), 32'h12CD);

    // Same-address double write.
    idle(); req(0, 1'b0, 5, 2'b01, 16'h1111); req(1, 1'b0, 5, 2'b11, 16'h2222); step();
    check("col_pulse", 32'(q_col[0]), 32'd1);
    idle(); req(1, 1'b1, 5, '0, '0); step();
    check("col_single", 32'(q_col[1]), 32'd0);
    check("col_data_lat1", 32'(q_data[0][1]), 32'h2211);
    idle(); step();
    check("col_data_lat2", 32'(q_data[1][1]), 32'h2211);

    // Cross-port read during write.
    idle(); req(0, 1'b0, 7, 2'b11, 16'h0F0F); step();
    idle(); req(0, 1'b0, 7, 2'b11, 16'hAAAA); req(1, 1'b1, 7, '0, '0); step();
    check("rdw_old", 32'(q_data[0][1]), 32'h0F0F);
    check("rdw_no_col", 32'(q_col[0]), 32'd0);
    idle(); step();
    check("rdw_new", 32'(q_data[1][1]), 32'hAAAA);

    // Distinct pattern, then a back-to-back stream on port 1.
    for (int a = 0; a < DEPTH; a++) begin
      idle(); req(0, 1'b0, a, 2'b11, W'(16'h1000 + a * 16'h0111)); step();
    end
    pulses = 0;
    for (int a = 0; a < DEPTH; a++) begin
      idle(); req(1, 1'b1, a, '0, '0); step();
      if (q_valid[1][1]) pulses++;
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      if (q_valid[1][1]) pulses++;
    end
    check("stream_pulses", 32'(pulses), 32'(DEPTH));
    check("stream_hold", 32'(q_data[1][1]), 32'h1000 + 32'(DEPTH - 1) * 32'h0111);

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 500; i++) begin
      idle();
      random_req(0);
      random_req(1);
      clear = ($urandom_range(0, 59) == 0);
      step();
    end

    // Reset in the middle of a clear sweep.
    for (int a = 0; a < DEPTH; a++) begin
      idle(); req(1, 1'b0, a, 2'b11, W'($urandom_range(1, 16'hFFFF))); step();
    end
    idle(); clear = 1'b1; step();
    idle();
    for (int i = 0; i < 8; i++) step();
    apply_reset();
    count_busy("rst_mid_busy_len", 1'b1);
    read_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
